// File: rtl/pu_lut_pkg.sv
// Shared definitions for the programmable LUT: FSM encoding and depth constants.
package pu_lut_pkg;

  localparam int unsigned LUT_ADDR_W = 4;
  localparam int unsigned LUT_DATA_W = 1;
  localparam int unsigned LUT_DEPTH  = 1 << LUT_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } lut_state_e;

  function automatic int unsigned lut_depth(input int unsigned aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/pu_lut_ram.sv
// LUT storage: synchronous write port, registered read port (read-before-write).
module pu_lut_ram #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents survive reset so a reset does not wipe a loaded table.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/pu_lut_writer.sv
// Session-based LUT loader: streams a counted run of entries into the RAM from a
// base address (wrapping), with a registered read port alongside.
module pu_lut_writer
  import pu_lut_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = LUT_ADDR_W,
  parameter int unsigned DATA_WIDTH = LUT_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic [ADDR_WIDTH:0]   load_count,
  input  logic                  load_abort,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int unsigned DEPTH = lut_depth(ADDR_WIDTH);
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [1:0]            rst_sync;
  logic                  rst_n;
  lut_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic                  err_d;
  logic                  xfer;
  logic                  count_ok;

  // Assert asynchronously, release two edges after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign xfer     = wr_valid && (state_q == ST_LOAD);
  assign count_ok = (load_count != '0) && (load_count <= CNT_W'(DEPTH));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    err_d   = err;
    case (state_q)
      ST_IDLE: begin
        // Abort wins over a simultaneous start.
        if (load_start && !load_abort) begin
          if (count_ok) begin
            state_d = ST_LOAD;
            ptr_d   = load_base;
            rem_d   = load_count;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
          rem_d = rem_q - CNT_W'(1);
        end
        if (load_abort)                          state_d = ST_IDLE;
        else if (xfer && rem_q == CNT_W'(1))     state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Protocol violations; these win over the clear on an accepted start.
    if (wr_valid && state_q != ST_LOAD)   err_d = 1'b1;
    if (load_start && state_q != ST_IDLE) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      rem_q    <= '0;
      wr_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      wr_ready <= (state_d == ST_LOAD);
      busy     <= (state_d != ST_IDLE);
      done     <= (state_d == ST_DONE);
      err      <= err_d;
    end
  end

  pu_lut_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (xfer),
    .waddr (ptr_q),
    .wdata (wr_data),
    .raddr (addr),
    .rdata (data)
  );

endmodule

// File: tb/tb_pu_lut_writer.sv
// Self-checking bench for pu_lut_writer: shadow memory plus read scoreboard.
module tb_pu_lut_writer;

  localparam int AW    = 4;
  localparam int DW    = 1;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [AW:0]   load_count;
  logic          load_abort;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;

  int total = 0;
  int bad   = 0;
  int done_pulses = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];

  pu_lut_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_base  (load_base),
    .load_count (load_count),
    .load_abort (load_abort),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .addr       (addr),
    .data       (data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_pulses++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Sweep every address, predicting from the shadow memory.
  task automatic read_all(input string tag);
    logic [DW-1:0] e;
    for (int a = 0; a < DEPTH; a++) begin
      addr = AW'(a);
      exp_q.push_back(model[a]);
      tick();
      e = exp_q.pop_front();
      total++;
      if (data !== e) begin
        bad++;
        $display("FAIL %s addr=%0d got=%b want=%b", tag, a, data, e);
      end
    end
  endtask

  task automatic run_load(input int base, input int cnt, input logic [15:0] pat,
                          input bit gap, input int abort_after, output int nwr);
    int n, cyc;
    bit ph, aborted, rdy;
    load_base  = AW'(base);
    load_count = (AW+1)'(cnt);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    total++;
    if (busy !== 1'b1 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL start busy=%b wr_ready=%b want 1/1", busy, wr_ready);
    end
    n = 0; cyc = 0; ph = 1'b0; aborted = 1'b0;
    while (n < cnt && !aborted && cyc < 200) begin
      cyc++;
      if (abort_after >= 0 && n == abort_after) begin
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        aborted = 1'b1;
      end else begin
        wr_valid = gap ? ph : 1'b1;
        ph = ~ph;
        wr_data = pat[n];
        rdy = wr_ready;
        tick();
        if (wr_valid && rdy) begin
          model[(base + n) % DEPTH] = pat[n];
          n++;
        end
        wr_valid = 1'b0;
      end
    end
    total++;
    if (cyc >= 200) begin
      bad++;
      $display("FAIL load_timeout written=%0d want=%0d", n, cnt);
    end else if (!aborted) begin
      if (done !== 1'b1 || busy !== 1'b1) begin
        bad++;
        $display("FAIL done_pulse done=%b busy=%b want 1/1", done, busy);
      end
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b0) begin
        bad++;
        $display("FAIL done_end done=%b busy=%b wr_ready=%b want 0/0/0", done, busy, wr_ready);
      end
    end else begin
      if (busy !== 1'b0 || wr_ready !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL abort_exit busy=%b wr_ready=%b done=%b want 0/0/0", busy, wr_ready, done);
      end
    end
    nwr = n;
  endtask

  task automatic test_reset;
    rst = 1'b0; load_start = 1'b0; load_base = '0; load_count = '0;
    load_abort = 1'b0; wr_valid = 1'b0; wr_data = '0; addr = '0;
    repeat (3) tick();
    total++;
    if ({wr_ready, busy, done, err, data} !== 5'b0) begin
      bad++;
      $display("FAIL reset_hold outs=%b want 00000", {wr_ready, busy, done, err, data});
    end
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({wr_ready, busy, done, err} !== 4'b0) begin
      bad++;
      $display("FAIL reset_release outs=%b want 0000", {wr_ready, busy, done, err});
    end
  endtask

  task automatic test_full_load;
    int n;
    done_pulses = 0;
    run_load(0, 16, 16'hAAAA, 1'b0, -1, n);
    total++;
    if (done_pulses != 1 || n != 16) begin
      bad++;
      $display("FAIL full_load done_pulses=%0d writes=%0d want 1/16", done_pulses, n);
    end
    read_all("full_read");
    total++;
    if (model[0] !== 1'b0 || model[1] !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL full_pattern m0=%b m1=%b err=%b want 0/1/0", model[0], model[1], err);
    end
  endtask

  task automatic test_wrap;
    int n;
    run_load(14, 4, 16'h0003, 1'b0, -1, n);
    read_all("wrap_read");
  endtask

  task automatic test_throttle;
    int n;
    done_pulses = 0;
    run_load(5, 3, 16'h0005, 1'b1, -1, n);
    total++;
    if (n != 3 || done_pulses != 1 || err !== 1'b0) begin
      bad++;
      $display("FAIL throttle writes=%0d done_pulses=%0d err=%b want 3/1/0", n, done_pulses, err);
    end
    read_all("throttle_read");
  endtask

  task automatic test_abort;
    int n;
    done_pulses = 0;
    run_load(8, 5, 16'h001D, 1'b0, 2, n);
    total++;
    if (n != 2 || done_pulses != 0) begin
      bad++;
      $display("FAIL abort writes=%0d done_pulses=%0d want 2/0", n, done_pulses);
    end
    run_load(10, 1, 16'h0001, 1'b0, -1, n);
    total++;
    if (err !== 1'b0 || n != 1) begin
      bad++;
      $display("FAIL abort_restart err=%b writes=%0d want 0/1", err, n);
    end
    read_all("abort_read");
  endtask

  task automatic test_read_before_write;
    logic [DW-1:0] oldv, e;
    oldv = model[3];
    load_base = 4'd3; load_count = 5'd1; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    wr_valid = 1'b1; wr_data = ~oldv; addr = 4'd3;
    exp_q.push_back(oldv);
    tick();
    wr_valid = 1'b0;
    model[3] = ~oldv;
    e = exp_q.pop_front();
    total++;
    if (data !== e) begin
      bad++;
      $display("FAIL rbw_old got=%b want=%b", data, e);
    end
    exp_q.push_back(model[3]);
    tick();
    e = exp_q.pop_front();
    total++;
    if (data !== e || busy !== 1'b0) begin
      bad++;
      $display("FAIL rbw_new got=%b busy=%b want=%b/0", data, busy, e);
    end
  endtask

  task automatic test_errors;
    int n;
    wr_valid = 1'b1; wr_data = ~model[0];
    tick();
    wr_valid = 1'b0;
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_stray_valid err=%b want 1", err);
    end
    read_all("err_mem_read");
    load_base = 4'd0; load_count = 5'd0; load_start = 1'b1;
    tick();
    load_count = 5'd17;
    tick();
    load_start = 1'b0;
    total++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL err_bad_count err=%b busy=%b want 1/0", err, busy);
    end
    run_load(2, 1, 16'h0001, 1'b0, -1, n);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear err=%b want 0", err);
    end
    load_base = 4'd6; load_count = 5'd2; load_start = 1'b1;
    tick();
    tick();
    load_start = 1'b0;
    total++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL err_start_busy err=%b busy=%b want 1/1", err, busy);
    end
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    read_all("err_final_read");
  endtask

  task automatic test_reset_midload;
    addr = 4'd14;
    tick();
    total++;
    if (data !== model[14] || model[14] !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_read got=%b want=%b", data, model[14]);
    end
    load_base = 4'd4; load_count = 5'd6; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_data = DW'(i);
      tick();
      model[4 + i] = DW'(i);
    end
    wr_valid = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    total++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midload_pre err=%b busy=%b want 1/1", err, busy);
    end
    wr_valid = 1'b1; wr_data = 1'b1;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({wr_ready, busy, done, err, data} !== 5'b0) begin
      bad++;
      $display("FAIL midload_reset outs=%b want 00000", {wr_ready, busy, done, err, data});
    end
    repeat (2) tick();
    wr_valid = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL post_reset busy=%b err=%b want 0/0", busy, err);
    end
    read_all("retained_read");
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_wrap();
    test_throttle();
    test_abort();
    test_read_before_write();
    test_errors();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
